barrel_shifter_dir: RTL and testbench
=====================================

Name: barrel_shifter_dir

Overview:
- Parameterised multistage (logarithmic) barrel shifter with a direction/mode select.
- Supports logical shift left/right and rotate left/right of a 2**NUM_STAGE-bit word by 0..2**NUM_STAGE-1 positions.
- Stage k conditionally shifts by 2**k under control bit cntrl[k]; the result is registered.
- Used as a generic datapath shift/rotate unit.

Parameters:
- NUM_STAGE, default 4: number of shift stages. Data width W = 2**NUM_STAGE (16 by default). Legal range 1..6.

Ports:
- clock, input, 1: single system clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- valid_in, input, 1: qualifies cntrl/data_in/dir this cycle.
- cntrl, input, NUM_STAGE: shift amount, unsigned 0..W-1.
- data_in, input, W: operand.
- dir, input, 2: operation select.
- data_out, output, W: registered result.
- valid_out, output, 1: data_out holds a result from a valid_in beat.

Behaviour:
- dir encoding:
  - 2'b00 SLL: shift left, zero fill.
  - 2'b01 SRL: shift right, zero fill.
  - 2'b10 ROL: rotate left.
  - 2'b11 ROR: rotate right.
- Structure: NUM_STAGE cascaded stages. Stage k (k = 0..NUM_STAGE-1) passes its input unchanged when cntrl[k]=0. When cntrl[k]=1 it applies the selected operation by 2**k. Net effect is the operation by the unsigned value of cntrl.
- Rotates are modulo W and lose no bits. Shifts discard bits moved past either end.
- cntrl=0: data_out = data_in for every dir.
- Maximum amount W-1:
  - SLL leaves only data_in[0] in bit W-1.
  - SRL leaves only data_in[W-1] in bit 0.
- Timing (default build): single output register, latency 1 cycle. Inputs sampled at rising edge N; data_out/valid_out valid after edge N (readable in cycle N+1).
- valid_out is valid_in delayed by the latency.
- data_out updates only when valid_in=1; otherwise it holds its previous value.
- Reset: on a rising edge with reset=1, data_out <= 0 and valid_out <= 0.
  - Reset overrides a simultaneous valid_in.
  - Reset asserted mid-operation discards all in-flight results.
- Full throughput: a new operation is accepted every cycle with no backpressure.
- No X propagation from unused encodings (all four dir codes are defined).

Optional Feature:
- Macro: BARREL_SHIFTER_PIPELINE_EN.
- Defined:
  - Pipeline register after every stage; latency NUM_STAGE cycles (4 at default).
  - valid and dir travel alongside the data through the pipeline; each stage's cntrl bit is carried forward too.
  - Throughput remains 1 operation per cycle.
  - Synchronous reset clears every stage's data and valid to 0.
- Not defined: stages are purely combinational with only the output register; latency 1.
- Functional result is identical in both builds; only latency differs.

Test Plan:
- SLL: cntrl=5, data_in=16'h0080, dir=00, valid_in=1 -> data_out=16'h1000 (4096), valid_out=1 after latency.
- SRL to empty: cntrl=4'b1111, data_in=16'h0080, dir=01 -> data_out=16'h0000.
- ROL: cntrl=15, data_in=16'h0080, dir=10 -> data_out=16'h0040. ROR: cntrl=8, data_in=16'h1234, dir=11 -> data_out=16'h3412.
- Pass-through and hold:
  - cntrl=0 with each dir, data_in=16'hA5C3 -> data_out=16'hA5C3.
  - Then valid_in=0 with changed inputs -> data_out unchanged, valid_out=0.
- Reset:
  - Issue back-to-back valid ops, then assert reset for one edge -> data_out=0, valid_out=0 next cycle; no stale result emerges afterwards (both builds).
  - Reset together with valid_in=1 -> output stays 0.
- Randomised: 100 random cntrl/dir with data_in=16'h0080 and random data, checked against a reference model at the build's latency.

Source files
------------

// File: rtl/barrel_shifter_dir.sv
// Logarithmic barrel shifter: SLL/SRL/ROL/ROR of a 2**NUM_STAGE-bit word, registered result.
// Define BARREL_SHIFTER_PIPELINE_EN to register every stage (latency NUM_STAGE instead of 1).
module barrel_shifter_dir #(
    parameter int NUM_STAGE = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [NUM_STAGE-1:0]        cntrl,
    input  logic [(2**NUM_STAGE)-1:0]   data_in,
    input  logic [1:0]                  dir,
    output logic [(2**NUM_STAGE)-1:0]   data_out,
    output logic                        valid_out
);

    localparam int W = 2**NUM_STAGE;

    // One stage: apply the selected operation by a fixed distance sh (sh <= W/2).
    function automatic logic [W-1:0] shift_step(input logic [W-1:0] x,
                                                input logic [1:0]   op,
                                                input int           sh);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = x << sh;
            2'b01:   r = x >> sh;
            2'b10:   r = (x << sh) | (x >> (W - sh));
            default: r = (x >> sh) | (x << (W - sh));
        endcase
        return r;
    endfunction

`ifdef BARREL_SHIFTER_PIPELINE_EN

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : stage_g
            localparam int SH = 2**gi;

            logic [W-1:0]           in_data;
            logic                   in_valid;
            logic [1:0]             in_dir;
            logic [NUM_STAGE-1:gi]  in_cntrl;
            logic [W-1:0]           out_d;
            logic [W-1:0]           data_q;
            logic                   valid_q;

            if (gi == 0) begin : g_src
                assign in_data  = data_in;
                assign in_valid = valid_in;
                assign in_dir   = dir;
                assign in_cntrl = cntrl;
            end else begin : g_src
                assign in_data  = stage_g[gi-1].data_q;
                assign in_valid = stage_g[gi-1].valid_q;
                assign in_dir   = stage_g[gi-1].g_carry.dir_q;
                assign in_cntrl = stage_g[gi-1].g_carry.cntrl_q;
            end

            assign out_d = in_cntrl[gi] ? shift_step(in_data, in_dir, SH) : in_data;

            // Data loads only on valid beats so the final stage holds its last result.
            always_ff @(posedge clock) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= out_d;
                    end
                end
            end

            // Only the control bits still needed downstream are carried forward.
            if (gi < NUM_STAGE - 1) begin : g_carry
                logic [1:0]               dir_q;
                logic [NUM_STAGE-1:gi+1]  cntrl_q;

                always_ff @(posedge clock) begin
                    if (in_valid) begin
                        dir_q   <= in_dir;
                        cntrl_q <= in_cntrl[NUM_STAGE-1:gi+1];
                    end
                end
            end
        end
    endgenerate

    assign data_out  = stage_g[NUM_STAGE-1].data_q;
    assign valid_out = stage_g[NUM_STAGE-1].valid_q;

`else

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;
    logic         valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGE; gi++) begin : stage_g
            localparam int SH = 2**gi;

            logic [W-1:0] in_d;
            logic [W-1:0] out_d;

            if (gi == 0) begin : g_src
                assign in_d = data_in;
            end else begin : g_src
                assign in_d = stage_g[gi-1].out_d;
            end

            assign out_d = cntrl[gi] ? shift_step(in_d, dir, SH) : in_d;
        end
    endgenerate

    assign data_d = stage_g[NUM_STAGE-1].out_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                data_q <= data_d;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

`endif

endmodule

// File: tb/tb_barrel_shifter_dir.sv
// Self-checking bench for barrel_shifter_dir: bit-mapping reference model plus directed literals.
// Honours BARREL_SHIFTER_PIPELINE_EN for the expected latency.
module tb_barrel_shifter_dir;

    localparam int NS = 4;
    localparam int W  = 16;
`ifdef BARREL_SHIFTER_PIPELINE_EN
    localparam int LAT = NS;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [NS-1:0] cntrl;
    logic [W-1:0]  data_in;
    logic [1:0]    dir;
    logic [W-1:0]  data_out;
    logic          valid_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    barrel_shifter_dir #(.NUM_STAGE(NS)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .cntrl     (cntrl),
        .data_in   (data_in),
        .dir       (dir),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

    // Reference: place each source bit at its destination index.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int n, input int op);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (op)
                0: if (i + n < W) r[i + n] = d[i];
                1: if (i >= n)    r[i - n] = d[i];
                2: r[(i + n) % W]     = d[i];
                default: r[(i - n + W) % W] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected-output model: results travel through a LAT-deep delay line.
    logic [W-1:0] pipe_d [LAT];
    logic         pipe_v [LAT];
    logic [W-1:0] exp_data;
    logic         exp_valid;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pipe_d[i] = '0;
            pipe_v[i] = 1'b0;
        end
        exp_data  = '0;
        exp_valid = 1'b0;
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
                exp_data  = '0;
                exp_valid = 1'b0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) begin
                    pipe_d[i] = pipe_d[i-1];
                    pipe_v[i] = pipe_v[i-1];
                end
                pipe_d[0] = ref_op(data_in, int'(cntrl), int'(dir));
                pipe_v[0] = valid_in;
                if (pipe_v[LAT-1]) exp_data = pipe_d[LAT-1];
                exp_valid = pipe_v[LAT-1];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("cycle_valid", {15'd0, valid_out}, {15'd0, exp_valid});
                check("cycle_data", data_out, exp_data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [NS-1:0] c, input logic [W-1:0] d, input logic [1:0] dr,
                          input logic [W-1:0] expv, input string name);
        cntrl    = c;
        data_in  = d;
        dir      = dr;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (LAT - 1) tick();
        check(name, data_out, expv);
        check({name, "_valid"}, {15'd0, valid_out}, 16'd1);
        $display("[TB] op %s cntrl=%0d data_in=%h dir=%0d -> data_out=%h", name, c, d, dr, data_out);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        cntrl    = '0;
        data_in  = '0;
        dir      = 2'b00;
        tick();
        tick();
        check("reset_data", data_out, 16'h0000);
        check("reset_valid", {15'd0, valid_out}, 16'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        check("model_sll", ref_op(16'h0080, 5, 0), 16'h1000);
        check("model_srl", ref_op(16'h0080, 15, 1), 16'h0000);
        check("model_rol", ref_op(16'h0080, 15, 2), 16'h0040);
        check("model_ror", ref_op(16'h1234, 8, 3), 16'h3412);

        run_op(4'd5,  16'h0080, 2'b00, 16'h1000, "sll5");
        run_op(4'd15, 16'h0080, 2'b01, 16'h0000, "srl_empty");
        run_op(4'd15, 16'h0080, 2'b10, 16'h0040, "rol15");
        run_op(4'd8,  16'h1234, 2'b11, 16'h3412, "ror8");
        run_op(4'd15, 16'h0001, 2'b00, 16'h8000, "sll_max");
        run_op(4'd15, 16'hFFFE, 2'b00, 16'h0000, "sll_max_drop");
        run_op(4'd15, 16'h8000, 2'b01, 16'h0001, "srl_max");
        run_op(4'd3,  16'h8001, 2'b11, 16'h3000, "ror3");
        for (int k = 0; k < 4; k++) begin
            run_op(4'd0, 16'hA5C3, k[1:0], 16'hA5C3, $sformatf("pass_dir%0d", k));
        end

        // Changed inputs without valid_in must not disturb the held result.
        cntrl   = 4'd3;
        data_in = 16'hFFFF;
        dir     = 2'b01;
        repeat (LAT + 2) tick();
        check("hold_data", data_out, 16'hA5C3);
        check("hold_valid", {15'd0, valid_out}, 16'd0);
        $display("[TB] hold data_out=%h valid_out=%b", data_out, valid_out);

        // Back-to-back ops, then a one-edge reset flushes everything in flight.
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cntrl   = 4'(k + 1);
            data_in = 16'h0F0F;
            dir     = 2'(k);
            tick();
        end
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("flush_data", data_out, 16'h0000);
        check("flush_valid", {15'd0, valid_out}, 16'd0);
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            check("flush_stale", {15'd0, valid_out}, 16'd0);
        end
        $display("[TB] flush data_out=%h valid_out=%b", data_out, valid_out);

        // Reset wins over a simultaneous valid beat.
        reset    = 1'b1;
        valid_in = 1'b1;
        cntrl    = 4'd0;
        data_in  = 16'hFFFF;
        dir      = 2'b00;
        tick();
        reset    = 1'b0;
        valid_in = 1'b0;
        check("rst_valid_data", data_out, 16'h0000);
        repeat (LAT + 1) tick();
        check("rst_valid_late_data", data_out, 16'h0000);
        check("rst_valid_late_valid", {15'd0, valid_out}, 16'd0);
        $display("[TB] reset+valid data_out=%h valid_out=%b", data_out, valid_out);

        for (int k = 0; k < 100; k++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            cntrl    = 4'($urandom_range(0, 15));
            dir      = 2'($urandom_range(0, 3));
            data_in  = (k < 50) ? 16'h0080 : 16'($urandom);
            tick();
            $display("[TB] rand %0d valid_in=%b cntrl=%0d dir=%0d data_in=%h", k, valid_in, cntrl, dir, data_in);
        end
        valid_in = 1'b0;
        repeat (LAT + 2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
